// File: rtl/pmux_onehot.sv
// pmux_onehot: registered one-hot select multiplexer with select-error detection
//
// Ports:
//    clock      - rising-edge clock
//    reset      - asynchronous active-high reset, clears every output
//    ip         - flattened channel data, channel k at [k*WIDTH +: WIDTH]
//    sel        - one-hot channel select, bit k picks channel k
//    sel_valid  - qualifies sel; sel and ip are ignored while low
//    err_clr    - synchronous clear of err_sticky and err_count
//    mux_op     - registered selected data, holds until the next accepted select
//    op_valid   - one-cycle pulse per accepted select
//    err        - one-cycle pulse per rejected select
//    err_sticky - set by err, cleared only by err_clr or reset
//    err_count  - saturating count of rejected selects
//
// Build option: define PMUX_PRIORITY_EN to accept a multi-hot sel as its
// lowest-index set bit; sel=0 is still rejected.
module pmux_onehot #(
   parameter int WIDTH     = 4,
   parameter int CHANNELS  = 3,
   parameter int CNT_WIDTH = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [CHANNELS*WIDTH-1:0] ip,
   input  logic [CHANNELS-1:0]       sel,
   input  logic                      sel_valid,
   input  logic                      err_clr,
   output logic [WIDTH-1:0]          mux_op,
   output logic                      op_valid,
   output logic                      err,
   output logic                      err_sticky,
   output logic [CNT_WIDTH-1:0]      err_count
);

   logic [CHANNELS-1:0] grant;
   logic [WIDTH-1:0]    data;
   logic                accept;
   logic                reject;

`ifdef PMUX_PRIORITY_EN
   // x & -x isolates the lowest set bit, turning any non-zero sel into one-hot
   assign grant = sel & (~sel + CHANNELS'(1));
`else
   assign grant = sel;
`endif

   // non-zero and clearing the lowest set bit leaves nothing -> exactly one-hot
   assign accept = sel_valid && grant != '0 && (grant & (grant - CHANNELS'(1))) == '0;
   assign reject = sel_valid && !accept;

   // AND-OR mux; exact because grant is one-hot whenever data is used
   always_comb begin
      data = '0;
      for (int k = 0; k < CHANNELS; k++)
         data = data | (grant[k] ? ip[k*WIDTH +: WIDTH] : '0);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mux_op     <= '0;
         op_valid   <= 1'b0;
         err        <= 1'b0;
         err_sticky <= 1'b0;
         err_count  <= '0;
      end else begin
         op_valid <= accept;
         err      <= reject;
         if (accept)
            mux_op <= data;
         // a rejected select coincident with err_clr counts as the first new error
         if (reject) begin
            err_sticky <= 1'b1;
            err_count  <= err_clr ? CNT_WIDTH'(1) : (&err_count ? err_count : err_count + CNT_WIDTH'(1));
         end else if (err_clr) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_pmux_onehot.sv
// tb_pmux_onehot: scoreboard bench for pmux_onehot (default and 2-bit counter instances)
module tb_pmux_onehot;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] ip = '0;
   logic [2:0]  sel = '0;
   logic        sel_valid = 1'b0;
   logic        err_clr = 1'b0;
   logic [3:0]  mux_op, mux_op2;
   logic        op_valid, err, err_sticky;
   logic        op_valid2, err2, err_sticky2;
   logic [7:0]  err_count;
   logic [1:0]  err_count2;

   typedef struct packed {
      logic [3:0] op;
      logic       v;
      logic       e;
      logic       s;
      logic [7:0] c;
      logic [1:0] c2;
   } exp_t;

   exp_t q[$];
   exp_t m;
   int   n_chk = 0;
   int   n_err = 0;

   pmux_onehot #(.WIDTH(4), .CHANNELS(3), .CNT_WIDTH(8)) u_dut (
      .clock(clock), .reset(reset), .ip(ip), .sel(sel), .sel_valid(sel_valid),
      .err_clr(err_clr), .mux_op(mux_op), .op_valid(op_valid), .err(err),
      .err_sticky(err_sticky), .err_count(err_count)
   );

   pmux_onehot #(.WIDTH(4), .CHANNELS(3), .CNT_WIDTH(2)) u_sat (
      .clock(clock), .reset(reset), .ip(ip), .sel(sel), .sel_valid(sel_valid),
      .err_clr(err_clr), .mux_op(mux_op2), .op_valid(op_valid2), .err(err2),
      .err_sticky(err_sticky2), .err_count(err_count2)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // reference: onehot via popcount, priority via explicit lowest-bit search
   task automatic predict(input logic v, input logic [2:0] s, input logic [11:0] d, input logic c);
      int   k;
      logic acc;
      k = -1;
      if ($countones(s) == 1) begin
         for (int i = 0; i < 3; i++) if (s[i]) k = i;
      end
`ifdef PMUX_PRIORITY_EN
      else if (s != 0) begin
         for (int i = 2; i >= 0; i--) if (s[i]) k = i;
      end
`endif
      acc = v && k >= 0;
      m.v = acc;
      m.e = v && !acc;
      if (acc) m.op = d[k*4 +: 4];
      if (m.e) begin
         m.s  = 1'b1;
         m.c  = c ? 8'd1 : (m.c == 8'hff ? m.c : m.c + 8'd1);
         m.c2 = c ? 2'd1 : (m.c2 == 2'd3 ? m.c2 : m.c2 + 2'd1);
      end else if (c) begin
         m.s  = 1'b0;
         m.c  = '0;
         m.c2 = '0;
      end
      q.push_back(m);
   endtask

   task automatic compare_all(input exp_t x);
      check("mux_op", mux_op, x.op);
      check("op_valid", op_valid, x.v);
      check("err", err, x.e);
      check("err_sticky", err_sticky, x.s);
      check("err_count", err_count, x.c);
      check("err_count_sat", err_count2, x.c2);
      check("sat_mux_op", mux_op2, x.op);
   endtask

   task automatic step(input logic v, input logic [2:0] s, input logic [11:0] d, input logic c);
      exp_t x;
      @(negedge clock);
      sel_valid = v;
      sel = s;
      ip = d;
      err_clr = c;
      predict(v, s, d, c);
      @(posedge clock);
      #1;
      check("queue_nonempty", q.size() != 0, 1);
      if (q.size() != 0) begin
         x = q.pop_front();
         compare_all(x);
      end
   endtask

   localparam logic [11:0] IPV = {4'b0100, 4'b0010, 4'b0001};

   initial begin
      m = '0;
      #2;
      compare_all('0);
      @(negedge clock);
      reset = 1'b0;
      // one output per input, back to back
      step(1, 3'b001, IPV, 0);
      step(1, 3'b010, IPV, 0);
      step(1, 3'b100, IPV, 0);
      // ip churn while idle must not reach mux_op
      for (int i = 0; i < 4; i++) step(0, 3'($urandom), 12'($urandom), 0);
      step(0, 3'b000, ~IPV, 0);
      // full sel sweep after an accepted sel=100
      step(1, 3'b100, IPV, 0);
      for (int s = 0; s < 8; s++) step(1, 3'(s), IPV, 0);
      // clear alone, then saturate the 2-bit counter, then clear racing a new error
      step(0, 3'b000, IPV, 1);
      for (int i = 0; i < 5; i++) step(1, 3'b000, IPV, 0);
      step(1, 3'b000, IPV, 1);
      step(0, 3'b000, IPV, 1);
      // random traffic
      for (int i = 0; i < 60; i++)
         step($urandom_range(0, 3) != 0, 3'($urandom), 12'($urandom), $urandom_range(0, 7) == 0);
      // asynchronous reset mid-cycle while an output is valid
      step(1, 3'b010, IPV, 0);
      reset = 1'b1;
      #1;
      m = '0;
      compare_all('0);
      #1;
      reset = 1'b0;
      step(1, 3'b100, IPV, 0);
      step(1, 3'b001, IPV, 0);
      check("queue_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
